// File: rtl/game_pkg.sv
// Shared definitions for the game controller: direction codes, input FSM
// states and a key-to-direction helper used by the input front end.
package game_pkg;

  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_LEFT  = 4'b0001;
  localparam logic [3:0] DIR_RIGHT = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_UP    = 4'b1000;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PULSE = 2'b01,
    HOLD  = 2'b10
  } state_t;

  // Key order is [0]=left, [1]=right, [2]=down, [3]=up; anything else is no move.
  function automatic logic [3:0] dir_from_keys(input logic [3:0] keys);
    logic [3:0] dir;
    case (keys)
      4'b0001: dir = DIR_LEFT;
      4'b0010: dir = DIR_RIGHT;
      4'b0100: dir = DIR_DOWN;
      4'b1000: dir = DIR_UP;
      default: dir = DIR_NONE;
    endcase
    return dir;
  endfunction

  function automatic logic is_one_hot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: two-flop synchroniser, then a stability counter that only
// lets the active-high level change after DEBOUNCE_CYCLES matching samples.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 20
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_n,
  output logic level
);

  logic             sync1_q;
  logic             sync2_q;
  logic             sample;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sample = ~sync2_q;

  // Any sample agreeing with the current level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sample != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign level = level_q;

endmodule

// File: rtl/direction_input.sv
// Direction front end: four debounced keys, press-edge detection and an FSM
// that emits one fixed-length one-hot move per accepted press.
module direction_input
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 20,
  parameter int PULSE_LEN       = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [3:0] key_n,
  output logic [3:0] direction,
  output logic [3:0] key_level,
  output logic       rejected
);

  localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  logic [3:0]    level_w;
  logic [3:0]    prev_level_q;
  logic          any_press;
  state_t        state_q;
  logic [PW-1:0] pcnt_q;
  logic [3:0]    dir_q;
  logic          rej_q;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clock  (clock),
      .reset_n(reset_n),
      .raw_n  (key_n[k]),
      .level  (level_w[k])
    );
  end

  assign any_press = |(level_w & ~prev_level_q);

  // Once a pulse starts it runs to completion; HOLD blocks rollover and repeat.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_level_q <= 4'b0000;
      state_q      <= IDLE;
      pcnt_q       <= '0;
      dir_q        <= DIR_NONE;
      rej_q        <= 1'b0;
    end else begin
      prev_level_q <= level_w;
      rej_q        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_press) begin
            if (enable && is_one_hot(level_w)) begin
              dir_q   <= dir_from_keys(level_w);
              pcnt_q  <= PW'(PULSE_LEN - 1);
              state_q <= PULSE;
            end else begin
              rej_q   <= 1'b1;
              state_q <= HOLD;
            end
          end
        end
        PULSE: begin
          if (pcnt_q == '0) begin
            dir_q   <= DIR_NONE;
            state_q <= HOLD;
          end else begin
            pcnt_q <= pcnt_q - PW'(1);
          end
        end
        HOLD: begin
          if (level_w == 4'b0000) begin
            state_q <= IDLE;
          end
        end
        default: begin
          dir_q   <= DIR_NONE;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign direction = dir_q;
  assign key_level = level_w;
  assign rejected  = rej_q;

endmodule

// File: tb/tb_direction_input.sv
// Self-checking bench for direction_input: a sample-window behavioural model
// compared every cycle, plus directed latency/length checks with literal values.
module tb_direction_input;

  localparam int DEB   = 4;
  localparam int CW    = 4;
  localparam int PLEN  = 8;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic [3:0] key_n;
  logic [3:0] direction;
  logic [3:0] key_level;
  logic       rejected;

  int checkCount = 0;
  int passCount  = 0;

  direction_input #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CW),
    .PULSE_LEN      (PLEN)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .enable   (enable),
    .key_n    (key_n),
    .direction(direction),
    .key_level(key_level),
    .rejected (rejected)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model: a key level flips once the last DEB synchronised
  // samples all disagree with it; moves are scheduled as PLEN-clock pulses.
  logic [3:0] mPipe1, mPipe2, mLvl, mPrev, mCode;
  logic [3:0] mWin [DEB];
  int         mRemain;
  bit         mWait;
  logic       mRej;
  logic [3:0] expDir;

  always @(posedge clock or negedge reset_n) begin
    logic [3:0] seen, lvlOld, prevOld, newLvl;
    bit         allDiff;
    if (!reset_n) begin
      mPipe1  = 4'b0000;
      mPipe2  = 4'b0000;
      mLvl    = 4'b0000;
      mPrev   = 4'b0000;
      mCode   = 4'b0000;
      mRemain = 0;
      mWait   = 1'b0;
      mRej    = 1'b0;
      for (int i = 0; i < DEB; i++) mWin[i] = 4'b0000;
    end else begin
      lvlOld  = mLvl;
      prevOld = mPrev;
      seen    = mPipe2;
      mPipe2  = mPipe1;
      mPipe1  = ~key_n;
      for (int i = DEB - 1; i > 0; i--) mWin[i] = mWin[i-1];
      mWin[0] = seen;
      newLvl  = lvlOld;
      for (int k = 0; k < 4; k++) begin
        allDiff = 1'b1;
        for (int i = 0; i < DEB; i++) if (mWin[i][k] == lvlOld[k]) allDiff = 1'b0;
        if (allDiff) newLvl[k] = ~lvlOld[k];
      end
      mRej = 1'b0;
      if (mRemain > 0) begin
        mRemain--;
        if (mRemain == 0) mWait = 1'b1;
      end else if (mWait) begin
        if (lvlOld == 4'b0000) mWait = 1'b0;
      end else if (|(lvlOld & ~prevOld)) begin
        if (enable && $countones(lvlOld) == 1) begin
          mRemain = PLEN;
          mCode   = lvlOld;
        end else begin
          mRej  = 1'b1;
          mWait = 1'b1;
        end
      end
      mPrev = lvlOld;
      mLvl  = newLvl;
    end
  end

  assign expDir = (mRemain > 0) ? mCode : 4'b0000;

  // Per-cycle comparison of all outputs against the model, away from posedge.
  always @(negedge clock) begin
    checkCount++;
    if (direction === expDir && key_level === mLvl && rejected === mRej) begin
      passCount++;
    end else begin
      $display("[TB] FAIL model t=%0t dir=%b/%b level=%b/%b rej=%b/%b (actual/required)",
               $time, direction, expDir, key_level, mLvl, rejected, mRej);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] keys, input logic en);
    @(negedge clock);
    key_n  = keys;
    enable = en;
  endtask

  task automatic waitDir(input logic [3:0] code, input string name, input int expEdges);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (direction !== code && n < 60);
    checkOutput(name, n, expEdges);
  endtask

  task automatic waitRejected(input string name, input int expEdges);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (rejected !== 1'b1 && n < 60);
    checkOutput(name, n, expEdges);
  endtask

  task automatic waitLevel(input logic [3:0] mask, input logic [3:0] value,
                           input string name, input int expEdges);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((key_level & mask) !== value && n < 60);
    checkOutput(name, n, expEdges);
  endtask

  task automatic pulseLen(input logic [3:0] code, input string name, input int dropAt);
    int len = 0;
    while (direction === code && len < 60) begin
      if (dropAt > 0 && len == dropAt) enable = 1'b0;
      @(negedge clock);
      len++;
    end
    checkOutput(name, len, PLEN);
  endtask

  task automatic idleCycles(input int n, output int dirSeen);
    dirSeen = 0;
    repeat (n) begin
      @(negedge clock);
      if (direction !== 4'b0000) dirSeen++;
    end
  endtask

  initial begin
    int seen;
    int lvlSeen;
    reset_n = 1'b1;
    enable  = 1'b1;
    key_n   = 4'b1111;
    #1 reset_n = 1'b0;
    #2;
    checkOutput("reset dir", direction, 0);
    checkOutput("reset level", key_level, 0);
    checkOutput("reset rej", rejected, 0);
    @(negedge clock);
    reset_n = 1'b1;
    idleCycles(50, seen);
    checkOutput("idle after reset", seen, 0);

    // Single left press, release, no repeat.
    applyStimulus(4'b1110, 1'b1);
    waitDir(4'b0001, "left latency", 7);
    pulseLen(4'b0001, "left length", 0);
    checkOutput("left level held", key_level, 4'b0001);
    repeat (15) @(negedge clock);
    applyStimulus(4'b1111, 1'b1);
    waitLevel(4'b0001, 4'b0000, "left release", 6);
    idleCycles(100, seen);
    checkOutput("no second pulse", seen, 0);

    // Bouncing up key, then stable low.
    seen    = 0;
    lvlSeen = 0;
    for (int i = 0; i < 10; i++) begin
      key_n[3] = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) begin
        @(negedge clock);
        if (direction !== 4'b0000) seen++;
        if (key_level[3] !== 1'b0) lvlSeen++;
      end
    end
    checkOutput("bounce no pulse", seen, 0);
    checkOutput("bounce level", lvlSeen, 0);
    key_n = 4'b0111;
    waitDir(4'b1000, "up latency", 7);
    pulseLen(4'b1000, "up length", 0);
    applyStimulus(4'b1111, 1'b1);
    waitLevel(4'b1111, 4'b0000, "up release", 6);
    idleCycles(3, seen);

    // Two keys together are rejected; then a clean down press.
    applyStimulus(4'b1100, 1'b1);
    waitRejected("two key reject", 7);
    checkOutput("two key dir", direction, 0);
    @(negedge clock);
    checkOutput("reject one clock", rejected, 0);
    idleCycles(20, seen);
    checkOutput("two key no pulse", seen, 0);
    applyStimulus(4'b1111, 1'b1);
    waitLevel(4'b1111, 4'b0000, "two key release", 6);
    idleCycles(3, seen);
    applyStimulus(4'b1011, 1'b1);
    waitDir(4'b0100, "down latency", 7);
    pulseLen(4'b0100, "down length", 0);
    applyStimulus(4'b1111, 1'b1);
    waitLevel(4'b1111, 4'b0000, "down release", 6);
    idleCycles(3, seen);

    // Enable gating, then enable dropped mid-pulse.
    applyStimulus(4'b1101, 1'b0);
    waitRejected("disabled reject", 7);
    idleCycles(20, seen);
    checkOutput("disabled no pulse", seen, 0);
    applyStimulus(4'b1111, 1'b0);
    waitLevel(4'b1111, 4'b0000, "disabled release", 6);
    idleCycles(3, seen);
    applyStimulus(4'b1101, 1'b1);
    waitDir(4'b0010, "right latency", 7);
    pulseLen(4'b0010, "right length enable drop", 3);
    applyStimulus(4'b1111, 1'b1);
    waitLevel(4'b1111, 4'b0000, "right release", 6);
    idleCycles(3, seen);

    // Reset on the third pulse clock, key still held afterwards.
    applyStimulus(4'b0111, 1'b1);
    waitDir(4'b1000, "pre-reset latency", 7);
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("reset truncates dir", direction, 0);
    checkOutput("reset clears level", key_level, 0);
    @(negedge clock);
    reset_n = 1'b1;
    waitDir(4'b1000, "post-reset latency", 7);
    pulseLen(4'b1000, "post-reset length", 0);
    applyStimulus(4'b1111, 1'b1);
    waitLevel(4'b1111, 4'b0000, "final release", 6);
    idleCycles(5, seen);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/direction_input.md
Name: direction_input

Overview:
- Front end for the game controller's `direction` input.
- Takes the four raw active-low pushbuttons and synchronises and debounces each one.
- Turns one clean press into a one-hot direction pulse held for exactly PULSE_LEN clocks.
- PULSE_LEN covers the controller's state register, which advances once every 8 clocks; each physical press yields one move, and holding a key never auto-repeats.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples needed to accept a key level change (board build uses 500000).
- CNT_W, 20, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- PULSE_LEN, 8, clocks that `direction` stays asserted per accepted press; must be at least 1.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  high = new presses may be accepted (controller drives low in the END state).
- key_n  in  4  raw pushbuttons, active-low: [0]=left, [1]=right, [2]=down, [3]=up.
- direction  out  4  one-hot move request: 0001 left, 0010 right, 0100 down, 1000 up; 0000 = none.
- key_level  out  4  debounced key state, active-high, for LEDs/debug.
- rejected  out  1  one-clock pulse when a press is discarded (multiple keys, or enable low).

Behaviour:
- Reset: asynchronous on reset_n low; all registers clear on reset_n assertion, independent of clock.
  - Synchroniser flops reset to 1 (released).
  - Debounced levels reset to released and counters to 0.
  - FSM resets to IDLE; direction=0000, key_level=0000, rejected=0.
  - Reset mid-pulse truncates the pulse immediately.
- Synchroniser: 2-flop per key on key_n; the synced value is inverted to active-high.
- Debounce, per key:
  - While the synced sample equals the debounced level, the counter holds at 0.
  - While they differ, the counter increments each clock.
  - On the edge where the counter would reach DEBOUNCE_CYCLES-1 and the sample still differs, the debounced level flips and the counter returns to 0.
  - Any intermediate sample equal to the debounced level resets the counter to 0, so glitches shorter than DEBOUNCE_CYCLES are ignored.
- Press event: a rising edge of any debounced level (registered previous level vs current).
- Press latency: from the first clock edge sampling key_n low (key stable thereafter), direction asserts after 2 + DEBOUNCE_CYCLES + 1 edges.
- FSM states: IDLE, PULSE, HOLD.
  - IDLE, press event with enable=1 and exactly one debounced key high → load direction with that key's one-hot code, load pulse counter with PULSE_LEN-1, go to PULSE.
  - IDLE, press event with enable=0, or more than one debounced key high → rejected=1 for one clock, direction stays 0000, go to HOLD.
  - PULSE: direction held constant and the counter decrements. When the counter is 0, clear direction on that edge and go to HOLD. Direction is therefore high for exactly PULSE_LEN clocks.
  - PULSE ignores other keys and enable changes; a started pulse always completes.
  - HOLD: wait until all debounced levels are 0, then go to IDLE. A press of another key while in HOLD is not queued, so no auto-repeat or rollover.
- key_level is always the debounced level; it is independent of the FSM.
- Simultaneous debounced rising edges on two keys in one clock count as the multiple-key case: rejected, then HOLD.

Decomposition:
- Shared package `game_pkg`:
  - Direction constants DIR_LEFT=4'b0001, DIR_RIGHT=4'b0010, DIR_DOWN=4'b0100, DIR_UP=4'b1000, DIR_NONE=4'b0000; the controller uses the same constants for its direction decode.
  - 2-bit state encoding IDLE=00, PULSE=01, HOLD=10.
- Sub-module `key_debounce` (params DEBOUNCE_CYCLES, CNT_W; ports clock, reset_n, raw_n, level), holding the synchroniser, counter and level register; instantiated four times.
- The top level holds edge detection, the FSM and the pulse counter.

Test Plan (DEBOUNCE_CYCLES=4, PULSE_LEN=8):
- Reset: reset_n=0 between clock edges → direction=0000, key_level=0000 immediately; after release with key_n=1111 they stay at 0 for 50 clocks.
- Single press: key_n=1110 held 30 clocks → direction=0001 rises 7 edges after the first low sample and lasts exactly 8 clocks; key_level[0]=1 while held. Then key_n=1111 → key_level[0]=0 after 6 edges; 100 further clocks show no second pulse.
- Bounce: key_n[3] toggles low/high every 2 clocks for 20 clocks, then held low → no pulse during toggling; a single direction=1000 pulse after stable low, rising 7 edges after the toggling stops.
- Two keys: key_n=1100 applied in one cycle → rejected=1 for one clock, direction stays 0000; release both, then press key_n=1011 → direction=0100 for 8 clocks.
- Enable gating: enable=0 and press right → rejected pulse, no direction. Then release, set enable=1, press right → 0010 pulse. Drop enable mid-pulse → pulse still lasts 8 clocks.
- Reset mid-pulse: assert reset_n=0 on the 3rd pulse clock → direction=0000 immediately. Release reset with the key still held → a fresh pulse after debounce, because the synced and debounced state restarted from released.
